bcedn_pindex_mem: RTL and testbench
===================================

Name: bcedn_pindex_mem

Overview:
- Pooling-index store between the encoder max-pool stage (writer) and the BCEDN decoder unpool stage (reader).
- Encoder side pushes one packed word of N_PE argmax indices per pooled output location, at sequential addresses.
- Decoder side issues pindex_rd with pindex_rd_addr; this block returns the word on pindex_in one cycle later.
- Tracks fill level, frame completion and protocol errors so the decoder start can be gated on ready.

Parameters:
- N_PE, 8, number of processing elements; one index field per PE in each word.
- POOL_H, 2, pooling window height.
- POOL_W, 2, pooling window width.
- PINDEX_WIDTH, $clog2(POOL_H*POOL_W) = 2, bits per per-PE index field.
- DEPTH, 1024, number of words stored; must be a power of two, at least 2.
- INDEX_ADDR_WIDTH, $clog2(DEPTH) = 10, address width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_start  input  1  one-cycle pulse: begin a new frame, clear the fill count.
- wr_en  input  1  write strobe from the encoder pool stage.
- wr_index  input  PINDEX_WIDTH*N_PE  packed indices; PE k occupies bits [k*PINDEX_WIDTH +: PINDEX_WIDTH].
- wr_last  input  1  qualifies wr_en; marks the final word of the frame.
- pindex_rd  input  1  read request from the decoder.
- pindex_rd_addr  input  INDEX_ADDR_WIDTH  read address.
- pindex_in  output  PINDEX_WIDTH*N_PE  read data, registered.
- pindex_vld  output  1  pindex_in is valid this cycle.
- ready  output  1  frame complete; decoder may start.
- wr_count  output  INDEX_ADDR_WIDTH+1  number of words written in the current frame.
- err_ovf  output  1  sticky: a write was attempted while FULL or DONE.
- err_rd  output  1  sticky: a read address was not below wr_count.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; pindex_in=0, pindex_vld=0, ready=0, wr_count=0, err_ovf=0, err_rd=0. Memory contents are not cleared.
- States: IDLE, FILL, FULL, DONE.
  - IDLE -> FILL on wr_start.
  - FILL -> DONE on an accepted write with wr_last=1.
  - FILL -> FULL when wr_count reaches DEPTH without wr_last.
  - FULL -> DONE on the next cycle.
  - DONE -> FILL on wr_start.
  - wr_start in any state: wr_count<=0, ready<=0, err_ovf<=0, err_rd<=0, go to FILL.
- Writes:
  - Accepted only in FILL with wr_en=1: mem[wr_count[INDEX_ADDR_WIDTH-1:0]]<=wr_index; wr_count increments.
  - wr_en in IDLE is ignored silently.
  - wr_en in FULL or DONE is dropped and sets err_ovf.
  - wr_start and wr_en in the same cycle: wr_start wins, the write is dropped, err_ovf is not set.
- ready: 1 in DONE only. It asserts the cycle after the wr_last write, or the cycle after FULL.
- Reads: accepted in every state; latency is exactly 1 cycle.
  - pindex_rd=1 at edge N gives pindex_vld=1 and pindex_in=data during cycle N+1.
  - pindex_rd=0 gives pindex_vld=0 next cycle; pindex_in holds its last value.
  - If pindex_rd_addr >= wr_count (compared against the value before any same-cycle write): pindex_in<=0, pindex_vld<=1, err_rd set.
- Read and write to the same address in the same cycle: read-first. Old contents are returned; since the address is >= the old wr_count, the result is 0 plus err_rd.
- Back-to-back reads are allowed every cycle, full throughput.
- Reset during FILL aborts the frame; a new wr_start is required.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> all outputs 0, state IDLE; wr_en pulses while in IDLE leave wr_count=0.
- Fill and readback, DEPTH=1024, N_PE=8:
  - Stimulus: wr_start, then 16 writes with wr_index=16'hA5A0+i, wr_last on i=15.
  - Response: ready=1 the cycle after the last write, wr_count=16.
  - Reading addresses 0..15 on consecutive cycles returns 16'hA5A0..16'hA5AF one cycle later, pindex_vld continuously high.
- Overflow: fill 1024 words with no wr_last -> FULL then DONE, ready=1, wr_count=1024. An extra wr_en sets err_ovf=1 and mem[0] is unchanged.
- Bad read: after a 16-word frame, read address 20 -> pindex_in=0, pindex_vld=1, err_rd=1. A following wr_start clears err_rd and ready.
- Same-cycle collision: during FILL with wr_count=5, write addr 5 with 16'h1234 and read addr 5 together -> read returns 0 and sets err_rd. The next read of addr 5 returns 16'h1234.
- Async reset mid-frame: drop rst after 7 writes -> outputs clear without waiting for a clock edge. A new wr_start plus 4 writes with wr_last gives wr_count=4, ready=1.

Source files
------------

// File: rtl/bcedn_pindex_mem.sv
// Pooling-index store: the encoder max-pool stage writes argmax words sequentially and
// the decoder unpool stage reads them back by address with one cycle of latency.
module bcedn_pindex_mem #(
    parameter int N_PE             = 8,
    parameter int POOL_H           = 2,
    parameter int POOL_W           = 2,
    parameter int PINDEX_WIDTH     = $clog2(POOL_H * POOL_W),
    parameter int DEPTH            = 1024,
    parameter int INDEX_ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_start,
    input  logic                             wr_en,
    input  logic [PINDEX_WIDTH*N_PE-1:0]     wr_index,
    input  logic                             wr_last,
    input  logic                             pindex_rd,
    input  logic [INDEX_ADDR_WIDTH-1:0]      pindex_rd_addr,
    output logic [PINDEX_WIDTH*N_PE-1:0]     pindex_in,
    output logic                             pindex_vld,
    output logic                             ready,
    output logic [INDEX_ADDR_WIDTH:0]        wr_count,
    output logic                             err_ovf,
    output logic                             err_rd
);
    localparam int DW = PINDEX_WIDTH * N_PE;
    localparam int CW = INDEX_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, FULL, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_accept;
    logic          ovf_hit;
    logic          rd_bad;
    logic [CW-1:0] wr_count_inc;

    assign wr_count_inc = wr_count + 1'b1;
    // Range check uses the pre-write count, so a same-cycle read of the slot being written is out of range.
    assign rd_bad = pindex_rd && ({1'b0, pindex_rd_addr} >= wr_count);
    assign ready  = (state == DONE);

    always_comb begin
        state_next = state;
        wr_accept  = 1'b0;
        ovf_hit    = 1'b0;
        if (wr_start) begin
            state_next = FILL;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                FILL: begin
                    if (wr_en) begin
                        wr_accept = 1'b1;
                        if (wr_last) begin
                            state_next = DONE;
                        end else if (wr_count_inc == DEPTH_CNT) begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    ovf_hit    = wr_en;
                    state_next = DONE;
                end
                DONE:    ovf_hit = wr_en;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_count <= '0;
            err_ovf  <= 1'b0;
            err_rd   <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_start) begin
                wr_count <= '0;
                err_ovf  <= 1'b0;
                err_rd   <= 1'b0;
            end else begin
                if (wr_accept) wr_count <= wr_count_inc;
                if (ovf_hit)   err_ovf  <= 1'b1;
                if (rd_bad)    err_rd   <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset so it can map onto a block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_count[INDEX_ADDR_WIDTH-1:0]] <= wr_index;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pindex_in  <= '0;
            pindex_vld <= 1'b0;
        end else begin
            pindex_vld <= pindex_rd;
            if (pindex_rd) begin
                pindex_in <= rd_bad ? '0 : mem[pindex_rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_bcedn_pindex_mem.sv
// Self-checking bench for bcedn_pindex_mem: directed frames plus randomized traffic,
// compared each cycle against a frame-level reference model.
module tb_bcedn_pindex_mem;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 16;

    localparam int PH_CLOSED    = 0;
    localparam int PH_OPEN      = 1;
    localparam int PH_SATURATED = 2;
    localparam int PH_COMPLETE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_start;
    logic          wr_en;
    logic [DW-1:0] wr_index;
    logic          wr_last;
    logic          pindex_rd;
    logic [AW-1:0] pindex_rd_addr;
    logic [DW-1:0] pindex_in;
    logic          pindex_vld;
    logic          ready;
    logic [AW:0]   wr_count;
    logic          err_ovf;
    logic          err_rd;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    int            m_phase;
    logic [DW-1:0] m_data;
    logic          m_vld;
    logic          m_ovf;
    logic          m_rd_err;

    bcedn_pindex_mem dut (
        .clk            (clk),
        .rst            (rst),
        .wr_start       (wr_start),
        .wr_en          (wr_en),
        .wr_index       (wr_index),
        .wr_last        (wr_last),
        .pindex_rd      (pindex_rd),
        .pindex_rd_addr (pindex_rd_addr),
        .pindex_in      (pindex_in),
        .pindex_vld     (pindex_vld),
        .ready          (ready),
        .wr_count       (wr_count),
        .err_ovf        (err_ovf),
        .err_rd         (err_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_phase  = PH_CLOSED;
        m_data   = '0;
        m_vld    = 1'b0;
        m_ovf    = 1'b0;
        m_rd_err = 1'b0;
    endtask

    // One clock edge worth of frame rules: read against the old count, then start/write/overflow.
    task automatic model_edge(input logic s_start, input logic s_en, input logic [DW-1:0] s_idx,
                              input logic s_last, input logic s_rd, input logic [AW-1:0] s_addr);
        int  old_cnt;
        logic bad;
        old_cnt = m_cnt;
        bad     = 1'b0;
        m_vld   = s_rd;
        if (s_rd) begin
            if (int'(s_addr) >= old_cnt) begin
                m_data = '0;
                bad    = 1'b1;
            end else begin
                m_data = m_mem[s_addr];
            end
        end
        if (s_start) begin
            m_cnt    = 0;
            m_phase  = PH_OPEN;
            m_ovf    = 1'b0;
            m_rd_err = 1'b0;
        end else begin
            if (bad) m_rd_err = 1'b1;
            if (m_phase == PH_OPEN && s_en) begin
                m_mem[old_cnt] = s_idx;
                m_cnt          = old_cnt + 1;
                if (s_last)              m_phase = PH_COMPLETE;
                else if (m_cnt == DEPTH) m_phase = PH_SATURATED;
            end else if (m_phase == PH_SATURATED) begin
                if (s_en) m_ovf = 1'b1;
                m_phase = PH_COMPLETE;
            end else if (m_phase == PH_COMPLETE && s_en) begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_output();
        check("pindex_in",  32'(pindex_in),  32'(m_data));
        check("pindex_vld", 32'(pindex_vld), 32'(m_vld));
        check("ready",      32'(ready),      32'(m_phase == PH_COMPLETE));
        check("wr_count",   32'(wr_count),   32'(m_cnt));
        check("err_ovf",    32'(err_ovf),    32'(m_ovf));
        check("err_rd",     32'(err_rd),     32'(m_rd_err));
    endtask

    task automatic apply_stimulus(input logic s_start, input logic s_en, input logic [DW-1:0] s_idx,
                                  input logic s_last, input logic s_rd, input logic [AW-1:0] s_addr);
        @(negedge clk);
        wr_start       = s_start;
        wr_en          = s_en;
        wr_index       = s_idx;
        wr_last        = s_last;
        pindex_rd      = s_rd;
        pindex_rd_addr = s_addr;
        @(posedge clk);
        if (rst) model_edge(s_start, s_en, s_idx, s_last, s_rd, s_addr);
        #1;
        check_output();
    endtask

    initial begin
        int a;
        rst            = 1'b0;
        wr_start       = 1'b0;
        wr_en          = 1'b0;
        wr_index       = '0;
        wr_last        = 1'b0;
        pindex_rd      = 1'b0;
        pindex_rd_addr = '0;
        model_reset();

        // Reset held for three cycles, with write strobes that must be ignored.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, '0);

        // 16-word frame and consecutive readback.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++)
            apply_stimulus(1'b0, 1'b1, 16'hA5A0 + 16'(i), (i == 15), 1'b0, '0);
        for (int i = 0; i < 16; i++)
            apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(i));
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        // Out-of-range read, then a new frame clears the error and ready.
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(20));
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Same-cycle write/read collision at address 5.
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, AW'(5));
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(5));
        apply_stimulus(1'b0, 1'b1, 16'h0777, 1'b1, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 16'h0888, 1'b0, 1'b0, '0);

        // Fill to capacity without wr_last, then an extra write and a readback of word 0.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(0));
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(DEPTH - 1));

        // Randomized mixed traffic.
        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(0, 8)) + m_cnt;
            if (a > DEPTH - 1) a = DEPTH - 1;
            apply_stimulus(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, 16'($urandom),
                           ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, AW'(a));
        end

        // Asynchronous reset in the middle of a frame.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++)
            apply_stimulus(1'b0, 1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b1, AW'(0));
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_output();
        apply_stimulus(1'b0, 1'b1, 16'h0BAD, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b0, 1'b1, 16'h0D00 + 16'(i), (i == 3), 1'b0, '0);
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(i));

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
